// File: rtl/l2_arbiter_pkg.sv
// lc3b_types: shared LC-3b widths plus the L2 arbiter state encoding.
//   lc3b_word       16-bit address/data word
//   lc3b_cacheline  128-bit cache line
//   lc3b_arb_state  arbiter FSM states
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cacheline;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } lc3b_arb_state;

endpackage

// File: rtl/l2_arbiter_if.sv
// l2_arbiter_if: bundles the I-cache, D-cache and L2 sides of the arbiter.
//   master modport: the arbiter (drives L1 responses and L2 requests)
//   slave  modport: the surrounding caches / L2 (drive requests and L2 data)
// Signals:
//   icache_pmem_read/address -> icache_pmem_rdata/resp
//   dcache_pmem_read/write/address/wdata -> dcache_pmem_rdata/resp
//   l2_read/l2_write/mem_address/l2_wdata -> l2_mem_rdata/l2_resp
interface l2_arbiter_if;
    import lc3b_types::*;

    logic          icache_pmem_read;
    lc3b_word      icache_pmem_address;
    lc3b_cacheline icache_pmem_rdata;
    logic          icache_pmem_resp;

    logic          dcache_pmem_read;
    logic          dcache_pmem_write;
    lc3b_word      dcache_pmem_address;
    lc3b_cacheline dcache_pmem_wdata;
    lc3b_cacheline dcache_pmem_rdata;
    logic          dcache_pmem_resp;

    logic          l2_read;
    logic          l2_write;
    lc3b_word      mem_address;
    lc3b_cacheline l2_wdata;
    lc3b_cacheline l2_mem_rdata;
    logic          l2_resp;

    modport master (
        input  icache_pmem_read, icache_pmem_address,
        output icache_pmem_rdata, icache_pmem_resp,
        input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        output dcache_pmem_rdata, dcache_pmem_resp,
        output l2_read, l2_write, mem_address, l2_wdata,
        input  l2_mem_rdata, l2_resp
    );

    modport slave (
        output icache_pmem_read, icache_pmem_address,
        input  icache_pmem_rdata, icache_pmem_resp,
        output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        input  dcache_pmem_rdata, dcache_pmem_resp,
        input  l2_read, l2_write, mem_address, l2_wdata,
        output l2_mem_rdata, l2_resp
    );

endinterface

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares one L2 port between the I-cache and D-cache.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - l2_arbiter_if.master (L1 request/response and L2 request/response)
// One transaction at a time: IDLE grants a side, SERVE_x holds the L2
// request from latched address/data until l2_resp, RELEASE spends one cycle
// so the served cache can drop its request before arbitration resumes.
module l2_arbiter
    import lc3b_types::*;
(
    input  logic         clk,
    input  logic         rst,
    l2_arbiter_if.master bus
);

    lc3b_arb_state state, state_n;
    logic          prio_d_last, prio_d_last_n;  // 1: D was served last, so I wins a tie
    lc3b_word      addr_q, addr_n;
    lc3b_cacheline wdata_q, wdata_n;
    logic          rd_q, rd_n;
    logic          wr_q, wr_n;

    logic i_req;
    logic d_req;
    logic grant_i;

    always_comb begin
        state_n       = state;
        prio_d_last_n = prio_d_last;
        addr_n        = addr_q;
        wdata_n       = wdata_q;
        rd_n          = rd_q;
        wr_n          = wr_q;

        i_req   = bus.icache_pmem_read;
        d_req   = bus.dcache_pmem_read | bus.dcache_pmem_write;
        // On a tie, serve the side that did not go last.
        grant_i = i_req & (~d_req | prio_d_last);

        bus.l2_read          = 1'b0;
        bus.l2_write         = 1'b0;
        bus.icache_pmem_resp = 1'b0;
        bus.dcache_pmem_resp = 1'b0;

        unique case (state)
            IDLE: begin
                if (grant_i) begin
                    state_n       = SERVE_I;
                    prio_d_last_n = 1'b0;
                    addr_n        = bus.icache_pmem_address & 16'hFFF0;
                    wdata_n       = bus.dcache_pmem_wdata;
                    rd_n          = 1'b1;
                    wr_n          = 1'b0;
                end else if (d_req) begin
                    state_n       = SERVE_D;
                    prio_d_last_n = 1'b1;
                    addr_n        = bus.dcache_pmem_address & 16'hFFF0;
                    wdata_n       = bus.dcache_pmem_wdata;
                    // Read and write together is a writeback only.
                    rd_n          = bus.dcache_pmem_read & ~bus.dcache_pmem_write;
                    wr_n          = bus.dcache_pmem_write;
                end
            end
            SERVE_I: begin
                bus.l2_read = 1'b1;
                if (bus.l2_resp) begin
                    bus.icache_pmem_resp = 1'b1;
                    state_n              = RELEASE;
                end
            end
            SERVE_D: begin
                bus.l2_read  = rd_q;
                bus.l2_write = wr_q;
                if (bus.l2_resp) begin
                    bus.dcache_pmem_resp = 1'b1;
                    state_n              = RELEASE;
                end
            end
            RELEASE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        bus.mem_address       = addr_q;
        bus.l2_wdata          = wdata_q;
        bus.icache_pmem_rdata = bus.l2_mem_rdata;
        bus.dcache_pmem_rdata = bus.l2_mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            prio_d_last <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
        end else begin
            state       <= state_n;
            prio_d_last <= prio_d_last_n;
            addr_q      <= addr_n;
            wdata_q     <= wdata_n;
            rd_q        <= rd_n;
            wr_q        <= wr_n;
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: directed scenarios for l2_arbiter with hand-computed expectations.
module tb_l2_arbiter;
    import lc3b_types::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    l2_arbiter_if bus ();

    l2_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam lc3b_cacheline LINE_A5 = {16{8'hA5}};
    localparam lc3b_cacheline LINE_DB = {4{32'hDEADBEEF}};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic clear_inputs();
        bus.icache_pmem_read    = 1'b0;
        bus.icache_pmem_address = '0;
        bus.dcache_pmem_read    = 1'b0;
        bus.dcache_pmem_write   = 1'b0;
        bus.dcache_pmem_address = '0;
        bus.dcache_pmem_wdata   = '0;
        bus.l2_mem_rdata        = '0;
        bus.l2_resp             = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_chk++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE); end
        n_chk++; if (bus.l2_read !== 1'b0 || bus.l2_write !== 1'b0) begin n_bad++; $display("FAIL reset_l2_req got=%b%b exp=00", bus.l2_read, bus.l2_write); end
        n_chk++; if (bus.icache_pmem_resp !== 1'b0 || bus.dcache_pmem_resp !== 1'b0) begin n_bad++; $display("FAIL reset_resp got=%b%b exp=00", bus.icache_pmem_resp, bus.dcache_pmem_resp); end
        n_chk++; if (bus.mem_address !== 16'h0) begin n_bad++; $display("FAIL reset_addr got=%h exp=0000", bus.mem_address); end
        n_chk++; if (bus.l2_wdata !== '0) begin n_bad++; $display("FAIL reset_wdata got=%h exp=0", bus.l2_wdata); end
        tick();
        rst = 1'b0;
        tick();
        n_chk++; if (dut.state !== IDLE || bus.l2_read !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle state=%0d l2_read=%b exp=IDLE,0", dut.state, bus.l2_read); end
    endtask

    task automatic test_single_i();
        bus.icache_pmem_read    = 1'b1;
        bus.icache_pmem_address = 16'h1234;
        #1;
        n_chk++; if (bus.l2_read !== 1'b0) begin n_bad++; $display("FAIL single_i_early got=%b exp=0", bus.l2_read); end
        tick();
        n_chk++; if (dut.state !== SERVE_I || bus.l2_read !== 1'b1 || bus.l2_write !== 1'b0) begin n_bad++; $display("FAIL single_i_grant state=%0d rd=%b wr=%b exp=1,1,0", dut.state, bus.l2_read, bus.l2_write); end
        n_chk++; if (bus.mem_address !== 16'h1230) begin n_bad++; $display("FAIL single_i_addr got=%h exp=1230", bus.mem_address); end
        n_chk++; if (bus.icache_pmem_resp !== 1'b0) begin n_bad++; $display("FAIL single_i_noresp got=%b exp=0", bus.icache_pmem_resp); end
        tick();
        tick();
        bus.l2_mem_rdata = LINE_A5;
        bus.l2_resp      = 1'b1;
        #1;
        n_chk++; if (bus.icache_pmem_resp !== 1'b1 || bus.icache_pmem_rdata !== LINE_A5) begin n_bad++; $display("FAIL single_i_resp resp=%b data=%h exp=1,a5..", bus.icache_pmem_resp, bus.icache_pmem_rdata); end
        n_chk++; if (bus.dcache_pmem_resp !== 1'b0) begin n_bad++; $display("FAIL single_i_dresp got=%b exp=0", bus.dcache_pmem_resp); end
        tick();
        bus.l2_resp          = 1'b0;
        bus.icache_pmem_read = 1'b0;
        #1;
        n_chk++; if (dut.state !== RELEASE || bus.icache_pmem_resp !== 1'b0 || bus.l2_read !== 1'b0) begin n_bad++; $display("FAIL single_i_release state=%0d resp=%b rd=%b exp=3,0,0", dut.state, bus.icache_pmem_resp, bus.l2_read); end
        tick();
        n_chk++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL single_i_idle got=%0d exp=0", dut.state); end
    endtask

    task automatic test_tie_after_reset();
        rst_pulse();
        bus.icache_pmem_read    = 1'b1;
        bus.icache_pmem_address = 16'h2000;
        bus.dcache_pmem_write   = 1'b1;
        bus.dcache_pmem_address = 16'h3000;
        bus.dcache_pmem_wdata   = LINE_A5;
        tick();
        n_chk++; if (dut.state !== SERVE_I || bus.mem_address !== 16'h2000) begin n_bad++; $display("FAIL tie_first_i state=%0d addr=%h exp=1,2000", dut.state, bus.mem_address); end
        bus.l2_resp = 1'b1;
        #1;
        n_chk++; if (bus.icache_pmem_resp !== 1'b1 || bus.dcache_pmem_resp !== 1'b0) begin n_bad++; $display("FAIL tie_i_resp i=%b d=%b exp=1,0", bus.icache_pmem_resp, bus.dcache_pmem_resp); end
        tick();
        bus.l2_resp          = 1'b0;
        bus.icache_pmem_read = 1'b0;
        #1;
        n_chk++; if (dut.state !== RELEASE) begin n_bad++; $display("FAIL tie_release got=%0d exp=3", dut.state); end
        tick();
        tick();
        n_chk++; if (dut.state !== SERVE_D || bus.l2_write !== 1'b1 || bus.l2_read !== 1'b0) begin n_bad++; $display("FAIL tie_then_d state=%0d rd=%b wr=%b exp=2,0,1", dut.state, bus.l2_read, bus.l2_write); end
        n_chk++; if (bus.mem_address !== 16'h3000 || bus.l2_wdata !== LINE_A5) begin n_bad++; $display("FAIL tie_d_addr addr=%h data=%h exp=3000,a5..", bus.mem_address, bus.l2_wdata); end
        bus.l2_resp = 1'b1;
        #1;
        n_chk++; if (bus.dcache_pmem_resp !== 1'b1 || bus.icache_pmem_resp !== 1'b0) begin n_bad++; $display("FAIL tie_d_resp d=%b i=%b exp=1,0", bus.dcache_pmem_resp, bus.icache_pmem_resp); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_contention();
        logic          exp_i;
        lc3b_arb_state exp_state;
        rst_pulse();
        bus.icache_pmem_read    = 1'b1;
        bus.icache_pmem_address = 16'h1111;
        bus.dcache_pmem_read    = 1'b1;
        bus.dcache_pmem_address = 16'h2222;
        for (int t = 0; t < 6; t++) begin
            exp_i     = (t % 2) == 0;
            exp_state = exp_i ? SERVE_I : SERVE_D;
            tick();
            n_chk++; if (dut.state !== exp_state) begin n_bad++; $display("FAIL contend_order_%0d got=%0d exp=%0d", t, dut.state, exp_state); end
            n_chk++; if (bus.mem_address !== (exp_i ? 16'h1110 : 16'h2220) || bus.l2_read !== 1'b1) begin n_bad++; $display("FAIL contend_req_%0d addr=%h rd=%b", t, bus.mem_address, bus.l2_read); end
            bus.l2_resp = 1'b1;
            #1;
            n_chk++; if (bus.icache_pmem_resp !== exp_i || bus.dcache_pmem_resp !== !exp_i) begin n_bad++; $display("FAIL contend_resp_%0d i=%b d=%b exp_i=%b", t, bus.icache_pmem_resp, bus.dcache_pmem_resp, exp_i); end
            tick();
            bus.l2_resp = 1'b0;
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_wdata_hold();
        bus.dcache_pmem_write   = 1'b1;
        bus.dcache_pmem_read    = 1'b1;
        bus.dcache_pmem_address = 16'h444C;
        bus.dcache_pmem_wdata   = LINE_DB;
        tick();
        bus.dcache_pmem_wdata   = '0;
        bus.dcache_pmem_address = 16'hFFFF;
        #1;
        n_chk++; if (bus.l2_write !== 1'b1 || bus.l2_read !== 1'b0) begin n_bad++; $display("FAIL rw_both_is_write rd=%b wr=%b exp=0,1", bus.l2_read, bus.l2_write); end
        tick();
        tick();
        n_chk++; if (bus.l2_wdata !== LINE_DB || bus.mem_address !== 16'h4440) begin n_bad++; $display("FAIL wdata_hold data=%h addr=%h exp=deadbeef..,4440", bus.l2_wdata, bus.mem_address); end
        bus.l2_resp = 1'b1;
        #1;
        n_chk++; if (bus.l2_wdata !== LINE_DB || bus.dcache_pmem_resp !== 1'b1) begin n_bad++; $display("FAIL wdata_at_resp data=%h resp=%b", bus.l2_wdata, bus.dcache_pmem_resp); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        bus.dcache_pmem_write   = 1'b1;
        bus.dcache_pmem_address = 16'h5000;
        bus.dcache_pmem_wdata   = LINE_A5;
        tick();
        n_chk++; if (dut.state !== SERVE_D || bus.l2_write !== 1'b1) begin n_bad++; $display("FAIL mid_pre state=%0d wr=%b exp=2,1", dut.state, bus.l2_write); end
        rst = 1'b1;
        #1;
        n_chk++; if (bus.l2_write !== 1'b0 || dut.state !== IDLE) begin n_bad++; $display("FAIL mid_async wr=%b state=%0d exp=0,0", bus.l2_write, dut.state); end
        n_chk++; if (bus.mem_address !== 16'h0 || bus.l2_wdata !== '0) begin n_bad++; $display("FAIL mid_regs addr=%h data=%h exp=0,0", bus.mem_address, bus.l2_wdata); end
        rst = 1'b0;
        clear_inputs();
        bus.l2_resp = 1'b1;
        #1;
        n_chk++; if (bus.dcache_pmem_resp !== 1'b0 || bus.icache_pmem_resp !== 1'b0) begin n_bad++; $display("FAIL mid_late_resp d=%b i=%b exp=0,0", bus.dcache_pmem_resp, bus.icache_pmem_resp); end
        tick();
        bus.l2_resp = 1'b0;
        n_chk++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL mid_stay_idle got=%0d exp=0", dut.state); end
    endtask

    task automatic test_spurious();
        bus.l2_mem_rdata = LINE_DB;
        bus.l2_resp      = 1'b1;
        #1;
        n_chk++; if (bus.icache_pmem_resp !== 1'b0 || bus.dcache_pmem_resp !== 1'b0) begin n_bad++; $display("FAIL spurious_resp i=%b d=%b exp=0,0", bus.icache_pmem_resp, bus.dcache_pmem_resp); end
        n_chk++; if (bus.icache_pmem_rdata !== LINE_DB || bus.dcache_pmem_rdata !== LINE_DB) begin n_bad++; $display("FAIL rdata_passthru i=%h d=%h", bus.icache_pmem_rdata, bus.dcache_pmem_rdata); end
        tick();
        bus.l2_resp = 1'b0;
        #1;
        n_chk++; if (dut.state !== IDLE || bus.l2_read !== 1'b0 || bus.l2_write !== 1'b0) begin n_bad++; $display("FAIL spurious_idle state=%0d rd=%b wr=%b exp=0,0,0", dut.state, bus.l2_read, bus.l2_write); end
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst   = 1'b1;
        clear_inputs();
        test_reset();
        test_single_i();
        test_tie_after_reset();
        test_contention();
        test_wdata_hold();
        test_reset_mid();
        test_spurious();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
